line_raster: RTL and testbench
==============================

// Module: line_raster
// PURPOSE
//  Downstream consumer of draw_line. After draw_line raises finish, reads back the len generated
//  points by driving index_rd and sampling line_x/line_y. Sets each in-range point in a W x H
//  1-bit bitmap and counts the clipped points. A pixel read port exposes the bitmap to the
//  display/check logic.
// PARAMETERS
//  W       32  bitmap width in pixels; x valid range 0..W-1
//  H       32  bitmap height in pixels; y valid range 0..H-1
//  RD_LAT   1  cycles from index_rd to valid line_x/line_y (draw_line read latency)
//  CLIP_W  16  width of clip_cnt
// PORTS
//  clk       in   1           single clock, rising edge
//  rst_n     in   1           asynchronous active-low reset
//  start     in   1           1-cycle pulse; latches len, begins a raster pass
//  len       in   32          number of points to read from draw_line
//  clear     in   1           1-cycle pulse; zeroes the bitmap (honoured in IDLE only)
//  finish    in   1           draw_line line-complete level
//  index_rd  out  32          point index presented to draw_line
//  line_x    in   32          point x from draw_line, unsigned
//  line_y    in   32          point y from draw_line, unsigned
//  rd_x      in   $clog2(W)   pixel read column
//  rd_y      in   $clog2(H)   pixel read row
//  rd_pix    out  1           bitmap[rd_y][rd_x], registered
//  busy      out  1           high in every state except IDLE
//  done      out  1           1-cycle pulse at end of pass
//  clip_cnt  out  CLIP_W      points dropped as out of range in the current/last pass
// BEHAVIOUR
//  Reset (async): state=IDLE; index_rd=0, busy=0, done=0, clip_cnt=0, rd_pix=0; bitmap all 0;
//   read pipeline valids cleared. Reset mid-pass aborts the pass with no further writes.
//  FSM IDLE->WAIT->ISSUE->DRAIN->DONE->IDLE:
//   IDLE : start=1 latches len_q=len and zeroes clip_cnt. len==0 -> DONE, else -> WAIT.
//   WAIT : stay until finish=1 is sampled (level; finish already high -> leave next edge).
//   ISSUE: index_rd=0,1,..,len_q-1, one per cycle. A valid bit enters an RD_LAT-deep shift
//          pipe with each index. Leave after index len_q-1 is presented.
//   DRAIN: stay until the pipe is empty.
//   DONE : done=1 for exactly one cycle, then IDLE. index_rd returns to 0 in IDLE.
//  Point write: when the pipe output is valid, sample line_x/line_y as unsigned.
//   x<W and y<H -> set bitmap[y][x]=1 (OR; setting an already-set pixel is harmless).
//   Otherwise no write; clip_cnt+=1, saturating at all-ones.
//  Latency: done is high N+RD_LAT+1 cycles after the edge that samples finish=1 in WAIT
//   (N=len_q). For len_q==0, done is high the cycle after start is sampled.
//  start while busy: ignored. clear while busy: ignored.
//  clear+start in the same IDLE cycle: both accepted; clear completes before the first write.
//  Read port: rd_pix updates one cycle after rd_x/rd_y. A read of a pixel being written in the
//   same cycle returns the pre-write value.
//  rd_x>=W or rd_y>=H: rd_pix=0.
//  len and finish are only sampled in the states listed above; changes elsewhere are ignored.
// STRUCTURE
//  line_raster_pkg: state enum (IDLE, WAIT, ISSUE, DRAIN, DONE) and default W/H/RD_LAT/CLIP_W.
//  Sub-module lr_bitmap: W*H flop array with async reset, 1-cycle clear, single write port and
//   registered read port. line_raster holds the FSM, index counter, valid pipe and clip counter.
// TESTING (draw_line stub: RD_LAT=1, point i = (3+i, 7))
//  start, len=5, finish high 3 cycles later -> index_rd 0..4 on consecutive cycles.
//   Pixels (3..7,7) set, clip_cnt=0. done 7 cycles after finish sampled.
//  Stub x=30+i, len=5 -> pixels (30,7),(31,7) set; clip_cnt=3.
//   Stub x=0xFFFFFFFF -> clipped, no write.
//  len=0 -> no index_rd activity; done pulses 1 cycle after start; bitmap unchanged.
//  rst_n low during ISSUE at index 2 -> outputs at reset values, bitmap all 0.
//   A new pass afterwards completes normally.
//  clear in IDLE after a pass -> every rd_pix reads 0.
//   clear during WAIT is ignored and the pixels persist. start during ISSUE is ignored.
//  RD_LAT=3 with the same stub, len=5 -> identical bitmap; done 9 cycles after finish sampled.

Source files
------------

// File: rtl/line_raster_pkg.sv
// Shared definitions for the line rasteriser: pass state encoding, default
// bitmap geometry and the point clipping rule.
package line_raster_pkg;

    localparam int unsigned LR_W      = 32;
    localparam int unsigned LR_H      = 32;
    localparam int unsigned LR_RD_LAT = 1;
    localparam int unsigned LR_CLIP_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        ISSUE,
        DRAIN,
        DONE
    } lr_state_e;

    // A point lands in the bitmap only when both unsigned coordinates fit.
    function automatic logic in_bounds(input logic [31:0] x, input logic [31:0] y,
                                       input int unsigned w, input int unsigned h);
        return (x < w) && (y < h);
    endfunction

endpackage

// File: rtl/lr_bitmap.sv
// W x H one-bit pixel store: async reset, single-cycle clear, one set-only
// write port and a registered read port.
module lr_bitmap
    import line_raster_pkg::*;
#(
    parameter int unsigned W = LR_W,
    parameter int unsigned H = LR_H
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr_i,
    input  logic                 we_i,
    input  logic [$clog2(W)-1:0] wx_i,
    input  logic [$clog2(H)-1:0] wy_i,
    input  logic [$clog2(W)-1:0] rx_i,
    input  logic [$clog2(H)-1:0] ry_i,
    output logic                 rd_pix_o
);

    localparam int unsigned XW = $clog2(W);
    localparam int unsigned YW = $clog2(H);

    logic [H-1:0][W-1:0] mem_q;
    logic                rd_pix_q;
    logic                rxOk;
    logic                ryOk;

    // Read coordinates can only fall outside the array when a dimension is not a power of two.
    if (W == (1 << XW)) begin : gXFull
        assign rxOk = 1'b1;
    end else begin : gXPart
        assign rxOk = (32'(rx_i) < W);
    end

    if (H == (1 << YW)) begin : gYFull
        assign ryOk = 1'b1;
    end else begin : gYPart
        assign ryOk = (32'(ry_i) < H);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else if (clr_i) begin
            mem_q <= '0;
        end else if (we_i) begin
            mem_q[wy_i][wx_i] <= 1'b1;
        end
    end

    // Samples the array before this cycle's write lands, so a same-cycle read sees the old pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pix_q <= 1'b0;
        end else begin
            rd_pix_q <= rxOk && ryOk && mem_q[ry_i][rx_i];
        end
    end

    assign rd_pix_o = rd_pix_q;

endmodule

// File: rtl/line_raster.sv
// Reads back the points produced by draw_line once it finishes, sets the
// in-range ones in a bitmap and counts the ones that fall outside it.
module line_raster
    import line_raster_pkg::*;
#(
    parameter int unsigned W      = LR_W,
    parameter int unsigned H      = LR_H,
    parameter int unsigned RD_LAT = LR_RD_LAT,
    parameter int unsigned CLIP_W = LR_CLIP_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [31:0]          len,
    input  logic                 clear,
    input  logic                 finish,
    output logic [31:0]          index_rd,
    input  logic [31:0]          line_x,
    input  logic [31:0]          line_y,
    input  logic [$clog2(W)-1:0] rd_x,
    input  logic [$clog2(H)-1:0] rd_y,
    output logic                 rd_pix,
    output logic                 busy,
    output logic                 done,
    output logic [CLIP_W-1:0]    clip_cnt
);

    localparam int unsigned XW = $clog2(W);
    localparam int unsigned YW = $clog2(H);

    lr_state_e         state_q, state_d;
    logic [31:0]       len_q, len_d;
    logic [31:0]       idx_q, idx_d;
    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [CLIP_W-1:0] clip_q, clip_d;
    logic [RD_LAT-1:0] vldShift;
    logic              issue;
    logic              ptValid;
    logic              ptInRange;
    logic              pipeTail;
    logic              clrBitmap;

    assign ptValid   = vld_q[RD_LAT-1];
    assign ptInRange = in_bounds(line_x, line_y, W, H);
    assign vldShift  = vld_q << 1;
    // Points still in flight behind the one currently at the pipe output.
    assign pipeTail  = |vldShift;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        clip_d    = clip_q;
        issue     = 1'b0;
        clrBitmap = 1'b0;

        case (state_q)
            IDLE: begin
                clrBitmap = clear;
                if (start) begin
                    len_d   = len;
                    clip_d  = '0;
                    state_d = (len == 32'd0) ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (finish) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                issue = 1'b1;
                if (idx_q == len_q - 32'd1) begin
                    idx_d   = '0;
                    state_d = DRAIN;
                end else begin
                    idx_d = idx_q + 32'd1;
                end
            end
            // Leaving as the last point reaches the output puts DONE on the cycle after its write.
            DRAIN: begin
                if (!pipeTail) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (ptValid && !ptInRange && (clip_q != '1)) begin
            clip_d = clip_q + 1'b1;
        end
    end

    always_comb begin
        vld_d    = vldShift;
        vld_d[0] = issue;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            vld_q   <= '0;
            clip_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
            clip_q  <= clip_d;
        end
    end

    lr_bitmap #(
        .W (W),
        .H (H)
    ) u_bitmap (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (clrBitmap),
        .we_i     (ptValid && ptInRange),
        .wx_i     (line_x[XW-1:0]),
        .wy_i     (line_y[YW-1:0]),
        .rx_i     (rd_x),
        .ry_i     (rd_y),
        .rd_pix_o (rd_pix)
    );

    assign index_rd = idx_q;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign clip_cnt = clip_q;

endmodule

// File: tb/tb_line_raster.sv
// Bench for line_raster: two instances (read latency 1 and 3) fed by draw_line
// stubs, compared against a point-list bitmap model kept in the bench.
module tb_line_raster;

    localparam int W = 32;
    localparam int H = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] len;
    logic        clear;
    logic        finish;
    logic [4:0]  rd_x;
    logic [4:0]  rd_y;

    logic [31:0] index1, lineX1, lineY1;
    logic        pix1, busy1, done1;
    logic [15:0] clip1;
    logic [31:0] index3, lineX3, lineY3, ia3, ib3;
    logic        pix3, busy3, done3;
    logic [15:0] clip3;

    logic [31:0] ptX [64];
    logic [31:0] ptY [64];
    bit          model [H][W];

    int assertCount = 0;
    int failCount   = 0;

    always #5 clk = ~clk;

    line_raster #(.W(W), .H(H), .RD_LAT(1), .CLIP_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .clear(clear), .finish(finish),
        .index_rd(index1), .line_x(lineX1), .line_y(lineY1), .rd_x(rd_x), .rd_y(rd_y),
        .rd_pix(pix1), .busy(busy1), .done(done1), .clip_cnt(clip1)
    );

    line_raster #(.W(W), .H(H), .RD_LAT(3), .CLIP_W(16)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .clear(clear), .finish(finish),
        .index_rd(index3), .line_x(lineX3), .line_y(lineY3), .rd_x(rd_x), .rd_y(rd_y),
        .rd_pix(pix3), .busy(busy3), .done(done3), .clip_cnt(clip3)
    );

    function automatic logic [31:0] fetchX(input logic [31:0] i);
        return (i < 64) ? ptX[i[5:0]] : 32'hDEAD_0000;
    endfunction

    function automatic logic [31:0] fetchY(input logic [31:0] i);
        return (i < 64) ? ptY[i[5:0]] : 32'hDEAD_0000;
    endfunction

    // draw_line stubs: point lookup registered RD_LAT cycles after index_rd
    always @(posedge clk) begin
        lineX1 <= fetchX(index1);
        lineY1 <= fetchY(index1);
    end

    always @(posedge clk) begin
        ia3    <= index3;
        ib3    <= ia3;
        lineX3 <= fetchX(ib3);
        lineY3 <= fetchY(ib3);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
            $error("[TB] check %s did not hold", tag);
        end
    endtask

    task automatic setupPoints(input int mode);
        for (int i = 0; i < 64; i++) begin
            case (mode)
                0: begin ptX[i] = 32'(3 + i);  ptY[i] = 32'd7; end
                1: begin ptX[i] = 32'(30 + i); ptY[i] = 32'd7; end
                2: begin ptX[i] = 32'hFFFF_FFFF; ptY[i] = 32'd7; end
                default: begin
                    ptX[i] = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 40));
                    ptY[i] = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 36));
                end
            endcase
        end
    endtask

    task automatic clearModel;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                model[y][x] = 1'b0;
    endtask

    task automatic scanBitmap(input string tag);
        int bad1 = 0;
        int bad3 = 0;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                rd_x = 5'(x);
                rd_y = 5'(y);
                tick();
                if (pix1 !== model[y][x]) bad1++;
                if (pix3 !== model[y][x]) bad3++;
            end
        end
        checkOutput({tag, " bad pixels lat1"}, 32'(bad1), 32'd0);
        checkOutput({tag, " bad pixels lat3"}, 32'(bad3), 32'd0);
    endtask

    // One full raster pass on both instances, from an idle start to the done pulse.
    task automatic applyStimulus(input string tag, input int n, input bit clrWithStart,
                                 input bit clrInWait, input bit startInIssue, input bit rdProbe);
        int expClip = 0;
        int first1  = -1;
        int first3  = -1;
        int cnt1    = 0;
        int cnt3    = 0;
        if (clrWithStart) clearModel();
        for (int i = 0; i < n; i++)
            if (!(ptX[i] < W && ptY[i] < H)) expClip++;
        if (rdProbe) begin
            rd_x = 5'd3;
            rd_y = 5'd7;
        end
        len   = 32'(n);
        start = 1'b1;
        clear = clrWithStart;
        tick();
        start = 1'b0;
        clear = 1'b0;
        len   = $urandom;
        if (n == 0) begin
            checkOutput({tag, " done1 after start"}, 32'(done1), 32'd1);
            checkOutput({tag, " done3 after start"}, 32'(done3), 32'd1);
            checkOutput({tag, " index1 idle"}, index1, 32'd0);
            tick();
            checkOutput({tag, " done1 one cycle"}, 32'(done1), 32'd0);
            checkOutput({tag, " busy3 back low"}, 32'(busy3), 32'd0);
            checkOutput({tag, " index3 idle"}, index3, 32'd0);
            return;
        end
        checkOutput({tag, " busy1 in wait"}, 32'(busy1), 32'd1);
        checkOutput({tag, " clip1 zeroed"}, 32'(clip1), 32'd0);
        checkOutput({tag, " clip3 zeroed"}, 32'(clip3), 32'd0);
        for (int w = 0; w < 3; w++) begin
            clear = clrInWait && (w == 0);
            tick();
        end
        clear = 1'b0;
        checkOutput({tag, " index1 in wait"}, index1, 32'd0);
        finish = 1'b1;
        for (int k = 1; k <= n + 12; k++) begin
            tick();
            if (k == 2) finish = 1'b0;
            start = startInIssue && (k == 2);
            checkOutput($sformatf("%s index1 k=%0d", tag, k), index1, (k <= n) ? 32'(k - 1) : 32'd0);
            checkOutput($sformatf("%s index3 k=%0d", tag, k), index3, (k <= n) ? 32'(k - 1) : 32'd0);
            if (done1) begin
                if (first1 < 0) first1 = k;
                cnt1++;
            end
            if (done3) begin
                if (first3 < 0) first3 = k;
                cnt3++;
            end
            if (rdProbe) begin
                checkOutput($sformatf("%s probe pix1 k=%0d", tag, k), 32'(pix1), (k >= 4) ? 32'd1 : 32'd0);
                checkOutput($sformatf("%s probe pix3 k=%0d", tag, k), 32'(pix3), (k >= 6) ? 32'd1 : 32'd0);
            end
        end
        start = 1'b0;
        checkOutput({tag, " done1 latency"}, 32'(first1), 32'(n + 2));
        checkOutput({tag, " done3 latency"}, 32'(first3), 32'(n + 4));
        checkOutput({tag, " done1 pulses"}, 32'(cnt1), 32'd1);
        checkOutput({tag, " done3 pulses"}, 32'(cnt3), 32'd1);
        checkOutput({tag, " clip1"}, 32'(clip1), 32'(expClip));
        checkOutput({tag, " clip3"}, 32'(clip3), 32'(expClip));
        checkOutput({tag, " busy1 end"}, 32'(busy1), 32'd0);
        checkOutput({tag, " busy3 end"}, 32'(busy3), 32'd0);
        for (int i = 0; i < n; i++)
            if (ptX[i] < W && ptY[i] < H) model[int'(ptY[i])][int'(ptX[i])] = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        len    = 32'd0;
        clear  = 1'b0;
        finish = 1'b0;
        rd_x   = 5'd0;
        rd_y   = 5'd0;
        setupPoints(0);
        clearModel();
        tick();
        tick();
        checkOutput("reset index1", index1, 32'd0);
        checkOutput("reset busy1", 32'(busy1), 32'd0);
        checkOutput("reset done3", 32'(done3), 32'd0);
        checkOutput("reset clip3", 32'(clip3), 32'd0);
        checkOutput("reset pix1", 32'(pix1), 32'd0);
        rst_n = 1'b1;
        tick();

        applyStimulus("basic", 5, 1'b0, 1'b0, 1'b0, 1'b1);
        scanBitmap("basic");

        setupPoints(1);
        applyStimulus("edge", 5, 1'b0, 1'b0, 1'b0, 1'b0);
        scanBitmap("edge");

        setupPoints(2);
        applyStimulus("allclip", 4, 1'b0, 1'b1, 1'b1, 1'b0);
        scanBitmap("wait clear ignored");

        applyStimulus("len0", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        scanBitmap("len0");

        clear = 1'b1;
        tick();
        clear = 1'b0;
        clearModel();
        scanBitmap("idle clear");

        setupPoints(3);
        applyStimulus("randA", $urandom_range(6, 40), 1'b0, 1'b0, 1'b0, 1'b0);
        scanBitmap("randA");
        setupPoints(3);
        applyStimulus("randB", $urandom_range(6, 40), 1'b1, 1'b0, 1'b0, 1'b0);
        scanBitmap("randB clear+start");

        setupPoints(0);
        len   = 32'd10;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        finish = 1'b1;
        tick();
        tick();
        tick();
        checkOutput("abort index1 before reset", index1, 32'd2);
        rst_n = 1'b0;
        #1;
        checkOutput("abort index1", index1, 32'd0);
        checkOutput("abort index3", index3, 32'd0);
        checkOutput("abort busy1", 32'(busy1), 32'd0);
        checkOutput("abort busy3", 32'(busy3), 32'd0);
        checkOutput("abort done1", 32'(done1), 32'd0);
        checkOutput("abort clip1", 32'(clip1), 32'd0);
        finish = 1'b0;
        tick();
        rst_n = 1'b1;
        clearModel();
        scanBitmap("abort");

        setupPoints(3);
        applyStimulus("after abort", $urandom_range(6, 40), 1'b0, 1'b0, 1'b0, 1'b0);
        scanBitmap("after abort");

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
